// File: rtl/riscv_mmu_biu_arbiter.sv
// riscv_mmu_biu_arbiter: shares one BIU request path between the instruction (port 0) and data (port 1) MMU sides
//
// Ports
//   rst_ni, clk_i                          asynchronous active-low reset, clock
//   flush_i                                pipeline flush; drops an unlocked owner
//   reqN_i/adrN_i/sizeN_i/lockN_i/weN_i    requester N (0 = instruction, 1 = data)
//   ackN_o                                 acknowledge routed to the owning requester only
//   req_o/adr_o/size_o/lock_o/we_o         downstream request, muxed from the owner
//   ack_i                                  downstream acknowledge
//   gnt_o                                  one-hot owner {port1,port0}; 00 when idle
//
// Build option
//   RV_MMU_ARB_ROUNDROBIN_EN  defined: a tie goes to the port that did not own last.
//                             undefined: a tie always goes to port 1 (data).

package riscv_mmu_biu_pkg;
  typedef enum logic [2:0] {
    BYTE  = 3'd0,
    HWORD = 3'd1,
    WORD  = 3'd2,
    DWORD = 3'd3,
    QWORD = 3'd4
  } biu_size_t;
endpackage

module riscv_mmu_biu_arbiter
  import riscv_mmu_biu_pkg::*;
#(
  parameter int PLEN = 32
) (
  input  logic            rst_ni,
  input  logic            clk_i,
  input  logic            flush_i,
  input  logic            req0_i,
  input  logic [PLEN-1:0] adr0_i,
  input  biu_size_t       size0_i,
  input  logic            lock0_i,
  input  logic            we0_i,
  output logic            ack0_o,
  input  logic            req1_i,
  input  logic [PLEN-1:0] adr1_i,
  input  biu_size_t       size1_i,
  input  logic            lock1_i,
  input  logic            we1_i,
  output logic            ack1_o,
  output logic            req_o,
  output logic [PLEN-1:0] adr_o,
  output biu_size_t       size_o,
  output logic            lock_o,
  output logic            we_o,
  input  logic            ack_i,
  output logic [1:0]      gnt_o
);
  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;
  state_t state_q, state_d, other_st;
  logic last_q, last_d;
  logic pick1, owned, own1, own_req, own_lock, oth_req;
  always_comb begin
`ifdef RV_MMU_ARB_ROUNDROBIN_EN
    pick1 = ~last_q;
`else
    pick1 = 1'b1 | last_q;
`endif
  end
  assign owned    = (state_q == OWN0) || (state_q == OWN1);
  assign own1     = state_q == OWN1;
  assign own_req  = own1 ? req1_i : req0_i;
  assign own_lock = own1 ? lock1_i : lock0_i;
  assign oth_req  = own1 ? req0_i : req1_i;
  assign other_st = own1 ? OWN0 : OWN1;
  always_comb begin
    state_d = state_q;
    req_o   = 1'b0;
    adr_o   = '0;
    size_o  = BYTE;
    lock_o  = 1'b0;
    we_o    = 1'b0;
    ack0_o  = 1'b0;
    ack1_o  = 1'b0;
    gnt_o   = 2'b00;
    if (owned) begin
      // a locked owner is immune to flush until it completes an unlocked transfer
      req_o  = own_req & ~(flush_i & ~own_lock);
      adr_o  = own1 ? adr1_i : adr0_i;
      size_o = own1 ? size1_i : size0_i;
      lock_o = own_lock;
      we_o   = own1 ? we1_i : we0_i;
      ack0_o = ~own1 & ack_i & req0_i;
      ack1_o = own1 & ack_i & req1_i;
      gnt_o  = {own1, ~own1};
      if (!own_req || (flush_i && !own_lock))
        state_d = IDLE;
      else if (ack_i && !own_lock)
        state_d = oth_req ? other_st : IDLE;
    end else begin
      state_d = (req1_i && (!req0_i || pick1)) ? OWN1 : req0_i ? OWN0 : IDLE;
    end
  end
  assign last_d = (state_d != IDLE && state_d != state_q) ? (state_d == OWN1) : last_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end
endmodule

// File: tb/tb_riscv_mmu_biu_arbiter.sv
// tb_riscv_mmu_biu_arbiter: randomized scoreboard bench for riscv_mmu_biu_arbiter
module tb_riscv_mmu_biu_arbiter;
  import riscv_mmu_biu_pkg::*;
`ifdef RV_MMU_ARB_ROUNDROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  typedef struct packed {
    logic        req;
    logic [31:0] adr;
    logic [2:0]  size;
    logic        lock;
    logic        we;
    logic        ack0;
    logic        ack1;
    logic [1:0]  gnt;
  } out_t;
  logic clk = 1'b0;
  logic rst_ni, flush, ack;
  logic rq [2];
  logic [31:0] ad [2];
  biu_size_t sz [2];
  logic lk [2];
  logic we [2];
  logic ack0_o, ack1_o, req_o, lock_o, we_o;
  logic [31:0] adr_o;
  biu_size_t size_o;
  logic [1:0] gnt_o;
  int own, last, vectors, errors;
  logic ack_seen [2];
  out_t expq [$];
  riscv_mmu_biu_arbiter #(.PLEN(32)) dut (
    .rst_ni(rst_ni), .clk_i(clk), .flush_i(flush),
    .req0_i(rq[0]), .adr0_i(ad[0]), .size0_i(sz[0]), .lock0_i(lk[0]), .we0_i(we[0]), .ack0_o(ack0_o),
    .req1_i(rq[1]), .adr1_i(ad[1]), .size1_i(sz[1]), .lock1_i(lk[1]), .we1_i(we[1]), .ack1_o(ack1_o),
    .req_o(req_o), .adr_o(adr_o), .size_o(size_o), .lock_o(lock_o), .we_o(we_o),
    .ack_i(ack), .gnt_o(gnt_o)
  );
  always #5 clk = ~clk;
  function automatic out_t dut_out();
    out_t o;
    o = '{req_o, adr_o, size_o, lock_o, we_o, ack0_o, ack1_o, gnt_o};
    return o;
  endfunction
  function automatic out_t model_out();
    out_t e = '0;
    if (own >= 0) begin
      e.req  = rq[own] & ~(flush & ~lk[own]);
      e.adr  = ad[own];
      e.size = sz[own];
      e.lock = lk[own];
      e.we   = we[own];
      e.ack0 = (own == 0) & ack & rq[0];
      e.ack1 = (own == 1) & ack & rq[1];
      e.gnt  = (own == 0) ? 2'b01 : 2'b10;
    end
    return e;
  endfunction
  function automatic void model_step();
    int y;
    if (own < 0) begin
      if (rq[0] && rq[1]) own = RR ? 1 - last : 1;
      else if (rq[0]) own = 0;
      else if (rq[1]) own = 1;
      if (own >= 0) last = own;
    end else begin
      y = 1 - own;
      if (!rq[own] || (flush && !lk[own])) own = -1;
      else if (ack && !lk[own]) begin
        own = rq[y] ? y : -1;
        if (own >= 0) last = own;
      end
    end
  endfunction
  task automatic chk(input string name, input out_t act, input out_t exp_v);
    vectors++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h expected %h (req adr size lock we ack0 ack1 gnt)", name, act, exp_v);
    end
  endtask
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (expq.size() > 0) chk("scoreboard", dut_out(), expq.pop_front());
    end
  end
  initial begin
    out_t e;
    vectors = 0;
    errors = 0;
    rst_ni = 1'b0;
    flush = 1'b0;
    ack = 1'b0;
    for (int p = 0; p < 2; p++) begin
      rq[p] = 1'b0; ad[p] = '0; sz[p] = BYTE; lk[p] = 1'b0; we[p] = 1'b0; ack_seen[p] = 1'b0;
    end
    own = -1;
    last = 1;
    repeat (2) @(negedge clk);
    chk("reset_outputs", dut_out(), '0);
    rst_ni = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      model_step();
      for (int p = 0; p < 2; p++) begin
        if (!rq[p] || ack_seen[p]) begin
          rq[p] = ($urandom_range(0, 2) != 0);
          ad[p] = $urandom;
          sz[p] = biu_size_t'($urandom_range(0, 4));
          lk[p] = ($urandom_range(0, 3) == 0);
          we[p] = 1'($urandom_range(0, 1));
        end else if (own == p && $urandom_range(0, 24) == 0) begin
          rq[p] = 1'b0;
        end
      end
      flush = ($urandom_range(0, 9) == 0);
      ack = 1'($urandom_range(0, 1));
      #1;
      e = model_out();
      ack_seen[0] = e.ack0;
      ack_seen[1] = e.ack1;
      expq.push_back(e);
    end
    @(negedge clk);
    #3;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected entries never compared, required 0", expq.size());
    end
    rq[1] = 1'b0; lk[1] = 1'b0;
    rq[0] = 1'b1; ad[0] = 32'h1000; sz[0] = WORD; lk[0] = 1'b0; we[0] = 1'b0;
    flush = 1'b0; ack = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    e = '0; e.req = 1'b1; e.adr = 32'h1000; e.size = 3'd2; e.gnt = 2'b01;
    chk("own0_before_reset", dut_out(), e);
    #1 rst_ni = 1'b0;
    #1 chk("async_reset", dut_out(), '0);
    @(negedge clk);
    rst_ni = 1'b1;
    #1 chk("no_grant_before_edge", dut_out(), '0);
    @(negedge clk);
    #1 chk("regrant_after_reset", dut_out(), e);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
